fifo_sync_prog: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the team's sync FIFO.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_sync_prog_if.sv | 45 ++++
 rtl/fifo_wrap_ptr.sv | 30 +++
 rtl/fifo_sync_prog.sv | 143 ++++++++++++++
 tb/tb_fifo_sync_prog.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
//   fifo_mode_e : read-port behaviour (standard registered read or first-word-fall-through)
//   fifo_aw()   : pointer width for a given depth, never less than one bit
package fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  // max(1, $clog2(depth)); a 2-entry FIFO still needs a 1-bit pointer.
  function automatic int fifo_aw(int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_prog_if.sv
// Bus bundle for fifo_sync_prog.
//   master : producer/consumer side, drives wr_en/data_in/rd_en/flush and thresholds
//   slave  : FIFO side, drives data_out/data_valid, per-cycle status and occupancy flags
// Handshake: a write is taken on a rising edge when wr_en=1 and the FIFO is not full
// (or is full and a read is taken on the same edge); a read is taken when rd_en=1 and
// the FIFO is not empty. Outcome of each request is reported the following cycle on
// wr_ack/overflow (write) and data_valid/underflow (read). flush overrides both requests.
interface fifo_sync_prog_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [CW-1:0]    pf_thresh;
  logic [CW-1:0]    pe_thresh;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             wr_ack;
  logic             overflow;
  logic             underflow;
  logic             full;
  logic             empty;
  logic             almostfull;
  logic             almostempty;
  logic             prog_full;
  logic             prog_empty;
  logic [CW-1:0]    count;

  modport master (
    output flush, wr_en, data_in, rd_en, pf_thresh, pe_thresh,
    input  data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, prog_full, prog_empty, count
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en, pf_thresh, pe_thresh,
    output data_out, data_valid, wr_ack, overflow, underflow,
           full, empty, almostfull, almostempty, prog_full, prog_empty, count
  );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer for fifo_sync_prog.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous return to 0 (flush)
//   inc        : advance by one, wrapping DEPTH-1 -> 0
//   ptr        : current pointer value, always < DEPTH
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW   = fifo_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  // Wrap is explicit so non-power-of-two depths index only valid entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read port,
// programmable full/empty thresholds, synchronous flush, write-on-full-with-read.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fifo_sync_prog_if.slave (requests, data, status, flags, count)
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_sync_prog_if.slave  bus
);

  localparam int         AW   = fifo_aw(DEPTH);
  localparam int         CW   = $clog2(DEPTH + 1);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_ack_q;
  logic             overflow_q;
  logic             underflow_q;

  logic empty_c;
  logic full_c;
  logic rd_ok;
  logic wr_ok;
  logic rd_acc;
  logic wr_acc;

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CW'(DEPTH));

  // A full FIFO can still take a write when a read frees a slot on the same edge.
  // On empty, a simultaneous write is not forwarded to the read side.
  assign rd_ok  = bus.rd_en & ~empty_c;
  assign wr_ok  = bus.wr_en & (~full_c | rd_ok);
  assign rd_acc = rd_ok & ~bus.flush;
  assign wr_acc = wr_ok & ~bus.flush;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.flush),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else if (wr_acc && !rd_acc) begin
      count_q <= count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_ok;
      overflow_q  <= bus.wr_en & ~wr_ok;
      underflow_q <= bus.rd_en & empty_c;
    end
  end

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      // data_out keeps the last word read; data_valid pulses one cycle per read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) begin
            data_q <= mem[rd_ptr];
          end
        end
      end

      assign bus.data_out   = data_q;
      assign bus.data_valid = valid_q;
    end else begin : g_fwft
      // Head word is shown directly; held at zero while empty so stale
      // storage never appears on the port (and reset reads back as zero).
      assign bus.data_out   = empty_c ? '0 : mem[rd_ptr];
      assign bus.data_valid = ~empty_c;
    end
  endgenerate

  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = full_c;
  assign bus.empty       = empty_c;
  assign bus.almostfull  = (count_q == CW'(DEPTH - 1));
  assign bus.almostempty = (count_q == CW'(1));
  assign bus.prog_full   = (count_q >= bus.pf_thresh);
  assign bus.prog_empty  = (count_q <= bus.pe_thresh);

  a_count_max : assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));
  a_wr_ptr    : assert property (@(posedge clk) disable iff (!rst_n) int'(wr_ptr) < DEPTH);
  a_rd_ptr    : assert property (@(posedge clk) disable iff (!rst_n) int'(rd_ptr) < DEPTH);
  a_wr_status : assert property (@(posedge clk) disable iff (!rst_n) !(wr_ack_q && overflow_q));
  a_empty     : assert property (@(posedge clk) disable iff (!rst_n) (count_q == '0) == empty_c);

endmodule

// File: tb/tb_fifo_sync_prog.sv
module tb_fifo_sync_prog;

  localparam int W  = 8;
  localparam int D  = 6;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sync_prog_if #(.WIDTH(W), .DEPTH(D)) bus_s ();
  fifo_sync_prog_if #(.WIDTH(W), .DEPTH(D)) bus_f ();

  fifo_sync_prog #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  fifo_sync_prog #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  // ---------------- scoreboard state ----------------
  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  exp_dout;
  logic          e_ack, e_ovf, e_udf, e_valid;
  logic [CW-1:0] pf, pe;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dout = '0;
    e_ack    = 1'b0;
    e_ovf    = 1'b0;
    e_udf    = 1'b0;
    e_valid  = 1'b0;
  endtask

  // Flags and per-cycle status common to both read modes.
  task automatic check_side(input string s, input logic [CW-1:0] cnt,
                            input logic f, input logic e, input logic af, input logic ae,
                            input logic pfo, input logic peo,
                            input logic ack, input logic ovf, input logic udf);
    int n;
    n = exp_q.size();
    chk({s, "_count"}, 32'(cnt), 32'(n));
    chk({s, "_full"}, 32'(f), 32'(n == D));
    chk({s, "_empty"}, 32'(e), 32'(n == 0));
    chk({s, "_almostfull"}, 32'(af), 32'(n == D - 1));
    chk({s, "_almostempty"}, 32'(ae), 32'(n == 1));
    chk({s, "_prog_full"}, 32'(pfo), 32'(n >= int'(pf)));
    chk({s, "_prog_empty"}, 32'(peo), 32'(n <= int'(pe)));
    chk({s, "_wr_ack"}, 32'(ack), 32'(e_ack));
    chk({s, "_overflow"}, 32'(ovf), 32'(e_ovf));
    chk({s, "_underflow"}, 32'(udf), 32'(e_udf));
  endtask

  task automatic check_outputs();
    check_side("std", bus_s.count, bus_s.full, bus_s.empty, bus_s.almostfull,
               bus_s.almostempty, bus_s.prog_full, bus_s.prog_empty,
               bus_s.wr_ack, bus_s.overflow, bus_s.underflow);
    check_side("fwft", bus_f.count, bus_f.full, bus_f.empty, bus_f.almostfull,
               bus_f.almostempty, bus_f.prog_full, bus_f.prog_empty,
               bus_f.wr_ack, bus_f.overflow, bus_f.underflow);
    chk("std_data_valid", 32'(bus_s.data_valid), 32'(e_valid));
    chk("std_data_out", 32'(bus_s.data_out), 32'(exp_dout));
    chk("fwft_data_valid", 32'(bus_f.data_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("fwft_data_out", 32'(bus_f.data_out), 32'(exp_q[0]));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic wr, input logic [W-1:0] d, input logic rd, input logic fl);
    bus_s.wr_en = wr;  bus_f.wr_en = wr;
    bus_s.data_in = d; bus_f.data_in = d;
    bus_s.rd_en = rd;  bus_f.rd_en = rd;
    bus_s.flush = fl;  bus_f.flush = fl;
    bus_s.pf_thresh = pf; bus_f.pf_thresh = pf;
    bus_s.pe_thresh = pe; bus_f.pe_thresh = pe;
  endtask

  // One clock of stimulus: predict, step past the edge, compare.
  task automatic cycle(input logic wr, input logic [W-1:0] d, input logic rd, input logic fl);
    logic m_empty, m_full, rd_ok, wr_ok;
    m_empty = (exp_q.size() == 0);
    m_full  = (exp_q.size() == D);
    rd_ok   = rd & ~m_empty;
    wr_ok   = wr & (~m_full | rd_ok);
    drive(wr, d, rd, fl);
    if (fl) begin
      exp_q.delete();
      e_ack = 1'b0; e_ovf = 1'b0; e_udf = 1'b0; e_valid = 1'b0;
    end else begin
      e_ack = wr_ok;
      e_ovf = wr & ~wr_ok;
      e_udf = rd & m_empty;
      e_valid = rd_ok;
      if (rd_ok) exp_dout = exp_q.pop_front();
      if (wr_ok) exp_q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    pf = CW'(D);
    pe = '0;
    model_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    // reset state
    check_outputs();
    chk("fwft_reset_data_out", 32'(bus_f.data_out), 32'h0);
    #10 rst_n = 1'b1;

    // 1: fill six, seventh write overflows
    for (int i = 0; i < D; i++) cycle(1'b1, W'(8'h10 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h16, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // 2: full, 13 cycles of simultaneous read/write wrap both pointers
    for (int i = 0; i < 13; i++) cycle(1'b1, W'($urandom_range(0, 255)), 1'b1, 1'b0);
    for (int i = 0; i < D; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 3: empty with read+write: write only, underflow reported
    cycle(1'b1, 8'hAA, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    // 4: standard read latency and single-cycle data_valid
    cycle(1'b1, 8'h31, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 5: programmable thresholds
    pf = CW'(4);
    pe = CW'(1);
    for (int i = 0; i < 4; i++) cycle(1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    // thresholds act combinationally, no clock needed
    pf = CW'(7);
    pe = '0;
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    chk("thr_prog_full_above_depth", 32'(bus_s.prog_full), 32'h0);
    chk("thr_prog_empty_zero", 32'(bus_f.prog_empty), 32'h0);
    pf = CW'(D);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // 6: flush with a pending write, then reset mid-burst
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h50 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'h5F, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 8'h61, 1'b0, 1'b0);
    cycle(1'b1, 8'h62, 1'b1, 1'b0);
    drive(1'b1, 8'h63, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("fwft_midreset_data_out", 32'(bus_f.data_out), 32'h0);
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
